// File: rtl/jtag_dmi_pkg.sv
// Shared DMI widths, op/status encodings, packed request word and host FSM states.
package jtag_dmi_pkg;

    localparam int unsigned DMI_ADDR_W = 6;
    localparam int unsigned DMI_DATA_W = 32;
    localparam int unsigned DMI_OP_W   = 2;
    localparam int unsigned DMI_REQ_W  = DMI_ADDR_W + DMI_DATA_W + DMI_OP_W;

    localparam logic [DMI_OP_W-1:0] DMI_OP_NOP   = 2'b00;
    localparam logic [DMI_OP_W-1:0] DMI_OP_READ  = 2'b01;
    localparam logic [DMI_OP_W-1:0] DMI_OP_WRITE = 2'b10;
    localparam logic [DMI_OP_W-1:0] DMI_RSP_OK   = 2'b00;
    localparam logic [DMI_OP_W-1:0] DMI_RSP_ERR  = 2'b11;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] addr;
        logic [DMI_DATA_W-1:0] data;
        logic [DMI_OP_W-1:0]   op;
    } dmi_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_REQ_REL,
        ST_RSP_WAIT,
        ST_RSP_ACK,
        ST_DONE
    } dmi_state_e;

    function automatic dmi_req_t dmi_pack(input logic [DMI_ADDR_W-1:0] addr,
                                          input logic [DMI_DATA_W-1:0] data,
                                          input logic [DMI_OP_W-1:0]   op);
        dmi_req_t r;
        r.addr = addr;
        r.data = data;
        r.op   = op;
        return r;
    endfunction

endpackage

// File: rtl/jtag_dmi_host_if.sv
// TAP-side command/response and DM-side 4-phase request/response signals of the DMI host.
interface jtag_dmi_host_if
    import jtag_dmi_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DMI_ADDR_W,
    parameter int unsigned DATA_BITS = DMI_DATA_W,
    parameter int unsigned OP_BITS   = DMI_OP_W
);
    localparam int unsigned REQ_BITS = ADDR_BITS + DATA_BITS + OP_BITS;

    logic                 cmd_valid_i;
    logic                 cmd_ready_o;
    logic [ADDR_BITS-1:0] cmd_addr_i;
    logic [DATA_BITS-1:0] cmd_data_i;
    logic [OP_BITS-1:0]   cmd_op_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [ADDR_BITS-1:0] rsp_addr_o;
    logic [DATA_BITS-1:0] rsp_data_o;
    logic [OP_BITS-1:0]   rsp_op_o;
    logic                 busy_o;
    logic                 err_o;
    logic                 err_clr_i;
    logic                 dtm_req_valid_o;
    logic [REQ_BITS-1:0]  dtm_req_data_o;
    logic                 dm_ack_i;
    logic                 dm_resp_valid_i;
    logic [REQ_BITS-1:0]  dm_resp_data_i;
    logic                 dtm_ack_o;

    modport master (
        input  cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_op_i, rsp_ready_i, err_clr_i,
               dm_ack_i, dm_resp_valid_i, dm_resp_data_i,
        output cmd_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_op_o, busy_o, err_o,
               dtm_req_valid_o, dtm_req_data_o, dtm_ack_o
    );

    modport slave (
        output cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_op_i, rsp_ready_i, err_clr_i,
               dm_ack_i, dm_resp_valid_i, dm_resp_data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_op_o, busy_o, err_o,
               dtm_req_valid_o, dtm_req_data_o, dtm_ack_o
    );

endinterface

// File: rtl/jtag_dmi_host_sync.sv
// Single-bit synchroniser: STAGES flops in series, asynchronously cleared.
module dmi_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/jtag_dmi_host.sv
// DMI initiator: one TAP command at a time, 4-phase request to the DM, 4-phase response
// back, with a per-phase timeout that aborts into an error response.
module jtag_dmi_host
    import jtag_dmi_pkg::*;
#(
    parameter int unsigned DMI_ADDR_BITS  = DMI_ADDR_W,
    parameter int unsigned DMI_DATA_BITS  = DMI_DATA_W,
    parameter int unsigned DMI_OP_BITS    = DMI_OP_W,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    jtag_dmi_host_if.master   bus
);
    localparam int unsigned A     = DMI_ADDR_BITS;
    localparam int unsigned D     = DMI_DATA_BITS;
    localparam int unsigned O     = DMI_OP_BITS;
    localparam int unsigned REQ_W = A + D + O;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    dmi_state_e        state_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic [A-1:0]      rsp_addr_q;
    logic [D-1:0]      rsp_data_q;
    logic [O-1:0]      rsp_op_q;
    logic              err_q;
    logic              req_valid_q;
    logic [REQ_W-1:0]  req_data_q;
    logic              ack_q;
    logic [TMO_W-1:0]  tmo_q;

    logic ack_s;
    logic rv_s;
    logic advance;
    logic waiting;
    logic tmo_hit;

    dmi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bus.dm_ack_i),
        .q_o   (ack_s)
    );

    dmi_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rv (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (bus.dm_resp_valid_i),
        .q_o   (rv_s)
    );

    // Condition that ends each handshake phase; a phase that ends never times out.
    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            ST_REQ:      advance = ack_s;
            ST_REQ_REL:  advance = !ack_s;
            ST_RSP_WAIT: advance = rv_s;
            ST_RSP_ACK:  advance = !rv_s;
            default:     advance = 1'b0;
        endcase
    end

    assign waiting = state_q inside {ST_REQ, ST_REQ_REL, ST_RSP_WAIT, ST_RSP_ACK};
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && waiting && !advance
                     && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            ack_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            tmo_q <= '0;
            if (tmo_hit) begin
                req_valid_q <= 1'b0;
                ack_q       <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_addr_q  <= req_data_q[REQ_W-1 -: A];
                rsp_data_q  <= '0;
                rsp_op_q    <= DMI_RSP_ERR;
                state_q     <= ST_DONE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.cmd_valid_i) begin
                            req_data_q  <= {bus.cmd_addr_i, bus.cmd_data_i, bus.cmd_op_i};
                            req_valid_q <= 1'b1;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (advance) begin
                            req_valid_q <= 1'b0;
                            state_q     <= ST_REQ_REL;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    ST_REQ_REL: begin
                        if (advance) state_q <= ST_RSP_WAIT;
                        else         tmo_q   <= tmo_q + 1'b1;
                    end
                    ST_RSP_WAIT: begin
                        if (advance) begin
                            rsp_addr_q <= bus.dm_resp_data_i[REQ_W-1 -: A];
                            rsp_data_q <= bus.dm_resp_data_i[O +: D];
                            rsp_op_q   <= bus.dm_resp_data_i[O-1:0];
                            ack_q      <= 1'b1;
                            state_q    <= ST_RSP_ACK;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    ST_RSP_ACK: begin
                        if (advance) begin
                            ack_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (bus.rsp_ready_i) begin
                            rsp_valid_q <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            // A timeout in the same cycle as a clear request leaves the error set.
            if (tmo_hit)            err_q <= 1'b1;
            else if (bus.err_clr_i) err_q <= 1'b0;
        end
    end

    assign bus.cmd_ready_o     = cmd_ready_q;
    assign bus.busy_o          = busy_q;
    assign bus.rsp_valid_o     = rsp_valid_q;
    assign bus.rsp_addr_o      = rsp_addr_q;
    assign bus.rsp_data_o      = rsp_data_q;
    assign bus.rsp_op_o        = rsp_op_q;
    assign bus.err_o           = err_q;
    assign bus.dtm_req_valid_o = req_valid_q;
    assign bus.dtm_req_data_o  = req_data_q;
    assign bus.dtm_ack_o       = ack_q;

endmodule

// File: tb/tb_jtag_dmi_host.sv
// Scoreboard bench for jtag_dmi_host: directed commands, a behavioural DM model and a
// response monitor that pops expected responses as the host presents them.
module tb_jtag_dmi_host;
    import jtag_dmi_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    jtag_dmi_host_if dif ();

    jtag_dmi_host #(
        .DMI_ADDR_BITS  (DMI_ADDR_W),
        .DMI_DATA_BITS  (DMI_DATA_W),
        .DMI_OP_BITS    (DMI_OP_W),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (dif.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    dmi_req_t req_exp_q[$];
    dmi_req_t dm_rsp_q[$];
    dmi_req_t rsp_exp_q[$];

    int dm_ack_dly   = 0;
    int dm_rsp_dly   = 0;
    int dm_hold      = 0;
    bit dm_early     = 1'b0;
    bit dm_never_ack = 1'b0;
    bit dm_skip_hold = 1'b0;
    bit dm_busy      = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic dm_cfg(input int ack_dly, input int rsp_dly, input int hold, input bit early);
        dm_ack_dly = ack_dly;
        dm_rsp_dly = rsp_dly;
        dm_hold    = hold;
        dm_early   = early;
    endtask

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic send(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op,
                        input bit keep, output int acc_cyc);
        int n;
        dif.cmd_addr_i  = a;
        dif.cmd_data_i  = d;
        dif.cmd_op_i    = op;
        dif.cmd_valid_i = 1'b1;
        n = 0;
        while (!dif.cmd_ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        chk("cmd_accept_wait", 64'(dif.cmd_ready_o), 64'(1'b1));
        @(posedge clk_i);
        #1;
        acc_cyc = cyc;
        if (!keep) dif.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((dm_busy || dif.busy_o || rsp_exp_q.size() != 0) && n < 400);
        chk({name, "_idle"}, 64'({dm_busy, dif.busy_o, rsp_exp_q.size() != 0}), 64'(0));
    endtask

    // Response scoreboard: one pop per rsp_valid/rsp_ready handshake.
    always @(negedge clk_i) begin
        if (!rst_i && dif.rsp_valid_o && dif.rsp_ready_i) begin
            if (rsp_exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(1), 64'(0));
            end else begin
                dmi_req_t e;
                e = rsp_exp_q.pop_front();
                chk("rsp", 64'({dif.rsp_addr_o, dif.rsp_data_o, dif.rsp_op_o}), 64'(e));
            end
        end
    end

    // Behavioural DM: acks the request, then answers through its response channel.
    initial begin : dm_model
        dmi_req_t er;
        dmi_req_t rr;
        int n;
        dif.dm_ack_i        = 1'b0;
        dif.dm_resp_valid_i = 1'b0;
        dif.dm_resp_data_i  = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && dif.dtm_req_valid_o && !dm_never_ack) begin
                dm_busy = 1'b1;
                er = '0;
                rr = '0;
                if (req_exp_q.size() != 0) er = req_exp_q.pop_front();
                else chk("req_unexpected", 64'(1), 64'(0));
                if (dm_rsp_q.size() != 0) rr = dm_rsp_q.pop_front();
                chk("req_data", 64'(dif.dtm_req_data_o), 64'(er));
                repeat (dm_ack_dly) @(negedge clk_i);
                chk("req_held", 64'({dif.dtm_req_valid_o, dif.dtm_req_data_o}), 64'({1'b1, er}));
                dif.dm_ack_i = 1'b1;
                n = 0;
                while (dif.dtm_req_valid_o && n < 64) begin
                    @(negedge clk_i);
                    n++;
                end
                chk("req_release", 64'(dif.dtm_req_valid_o), 64'(0));
                if (dm_early) begin
                    dif.dm_resp_data_i  = rr;
                    dif.dm_resp_valid_i = 1'b1;
                    repeat (4) @(negedge clk_i);
                    chk("early_no_ack", 64'(dif.dtm_ack_o), 64'(0));
                    dif.dm_ack_i = 1'b0;
                end else begin
                    dif.dm_ack_i = 1'b0;
                    repeat (dm_rsp_dly) @(negedge clk_i);
                    dif.dm_resp_data_i  = rr;
                    dif.dm_resp_valid_i = 1'b1;
                end
                n = 0;
                while (!dif.dtm_ack_o && n < 64) begin
                    @(negedge clk_i);
                    n++;
                end
                chk("dtm_ack_rise", 64'(dif.dtm_ack_o), 64'(1));
                repeat (dm_hold) @(negedge clk_i);
                if (dm_hold > 0 && !dm_skip_hold) chk("dtm_ack_held", 64'(dif.dtm_ack_o), 64'(1));
                dif.dm_resp_valid_i = 1'b0;
                n = 0;
                while (dif.dtm_ack_o && n < 64) begin
                    @(negedge clk_i);
                    n++;
                end
                chk("dtm_ack_fall", 64'(dif.dtm_ack_o), 64'(0));
                dif.dm_resp_data_i = '0;
                dm_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin : stimulus
        int a0;
        int a1;
        int n;
        dif.cmd_valid_i = 1'b0;
        dif.cmd_addr_i  = '0;
        dif.cmd_data_i  = '0;
        dif.cmd_op_i    = '0;
        dif.rsp_ready_i = 1'b1;
        dif.err_clr_i   = 1'b0;

        repeat (2) @(negedge clk_i);
        chk("reset_ctrl", 64'({dif.cmd_ready_o, dif.rsp_valid_o, dif.busy_o, dif.err_o,
                               dif.dtm_req_valid_o, dif.dtm_ack_o}), 64'(6'b100000));
        chk("reset_rsp", 64'({dif.rsp_addr_o, dif.rsp_data_o, dif.rsp_op_o}), 64'(0));
        chk("reset_req", 64'(dif.dtm_req_data_o), 64'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        // Write: request word is {04, DEADBEEF, 10} = 40'h137AB6FBBE.
        dm_cfg(3, 1, 0, 1'b0);
        req_exp_q.push_back(dmi_pack(6'h04, 32'hDEADBEEF, DMI_OP_WRITE));
        dm_rsp_q.push_back(dmi_pack(6'h04, 32'h0, DMI_RSP_OK));
        rsp_exp_q.push_back(dmi_pack(6'h04, 32'h0, DMI_RSP_OK));
        send(6'h04, 32'hDEADBEEF, DMI_OP_WRITE, 1'b0, a0);
        chk("write_req_word", 64'(dif.dtm_req_data_o), 64'(40'h137AB6FBBE));
        wait_idle("write");

        // Read with the DM holding its response valid for a while after dtm_ack_o.
        dm_cfg(2, 2, 5, 1'b0);
        req_exp_q.push_back(dmi_pack(6'h11, 32'h0, DMI_OP_READ));
        dm_rsp_q.push_back(dmi_pack(6'h11, 32'h00430C82, DMI_RSP_OK));
        rsp_exp_q.push_back(dmi_pack(6'h11, 32'h00430C82, DMI_RSP_OK));
        send(6'h11, 32'h0, DMI_OP_READ, 1'b0, a0);
        wait_idle("read");

        // Early response: valid rises while the DM still holds ack.
        dm_cfg(1, 0, 0, 1'b1);
        req_exp_q.push_back(dmi_pack(6'h07, 32'h0, DMI_OP_READ));
        dm_rsp_q.push_back(dmi_pack(6'h07, 32'h12345678, DMI_RSP_OK));
        rsp_exp_q.push_back(dmi_pack(6'h07, 32'h12345678, DMI_RSP_OK));
        send(6'h07, 32'h0, DMI_OP_READ, 1'b0, a0);
        wait_idle("early");

        // Back-to-back with a far side taking S+1 cycles per phase: 4*(2+1)+1 = 13.
        dm_cfg(0, 3, 0, 1'b0);
        req_exp_q.push_back(dmi_pack(6'h05, 32'h0, DMI_OP_READ));
        dm_rsp_q.push_back(dmi_pack(6'h05, 32'hCAFEF00D, DMI_RSP_OK));
        rsp_exp_q.push_back(dmi_pack(6'h05, 32'hCAFEF00D, DMI_RSP_OK));
        req_exp_q.push_back(dmi_pack(6'h3F, 32'h00000001, DMI_OP_NOP));
        dm_rsp_q.push_back(dmi_pack(6'h3F, 32'h0, DMI_RSP_OK));
        rsp_exp_q.push_back(dmi_pack(6'h3F, 32'h0, DMI_RSP_OK));
        send(6'h05, 32'h0, DMI_OP_READ, 1'b1, a0);
        dif.cmd_addr_i = 6'h3F;
        dif.cmd_data_i = 32'h00000001;
        dif.cmd_op_i   = DMI_OP_NOP;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!dif.rsp_valid_o && n < 100);
        chk("b2b_latency1", 64'(n), 64'(13));
        send(6'h3F, 32'h00000001, DMI_OP_NOP, 1'b0, a1);
        chk("b2b_accept_gap", 64'(a1 - a0), 64'(14));
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!dif.rsp_valid_o && n < 100);
        chk("b2b_latency2", 64'(n), 64'(13));
        wait_idle("b2b");

        // Timeout: DM never acks; request held 16 cycles then aborted.
        dm_never_ack = 1'b1;
        rsp_exp_q.push_back(dmi_pack(6'h2A, 32'h0, DMI_RSP_ERR));
        send(6'h2A, 32'h55AA55AA, DMI_OP_WRITE, 1'b0, a0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (!dif.dtm_req_valid_o) break;
            n++;
        end
        chk("tmo_req_cycles", 64'(n), 64'(16));
        chk("tmo_err_set", 64'({dif.err_o, dif.dtm_ack_o}), 64'(2'b10));
        repeat (3) @(negedge clk_i);
        chk("tmo_err_sticky", 64'(dif.err_o), 64'(1));
        dif.err_clr_i = 1'b1;
        @(negedge clk_i);
        dif.err_clr_i = 1'b0;
        chk("tmo_err_clear", 64'(dif.err_o), 64'(0));
        wait_idle("tmo");

        // Timeout with clear held: the set wins, the clear takes effect a cycle later.
        rsp_exp_q.push_back(dmi_pack(6'h19, 32'h0, DMI_RSP_ERR));
        dif.err_clr_i = 1'b1;
        send(6'h19, 32'h0, DMI_OP_READ, 1'b0, a0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (!dif.dtm_req_valid_o) break;
            n++;
        end
        chk("tmo2_req_cycles", 64'(n), 64'(16));
        chk("tmo2_err_prio", 64'(dif.err_o), 64'(1));
        @(negedge clk_i);
        chk("tmo2_err_clear", 64'(dif.err_o), 64'(0));
        dif.err_clr_i = 1'b0;
        dm_never_ack = 1'b0;
        wait_idle("tmo2");

        // Reset while in RSP_ACK: outputs clear without waiting for a clock edge.
        dm_cfg(0, 1, 20, 1'b0);
        dm_skip_hold = 1'b1;
        req_exp_q.push_back(dmi_pack(6'h22, 32'h0, DMI_OP_READ));
        dm_rsp_q.push_back(dmi_pack(6'h22, 32'h0BADF00D, DMI_RSP_OK));
        send(6'h22, 32'h0, DMI_OP_READ, 1'b0, a0);
        n = 0;
        while (!dif.dtm_ack_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst_reach_rsp_ack", 64'(dif.dtm_ack_o), 64'(1));
        repeat (2) @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_async_ctrl", 64'({dif.dtm_ack_o, dif.rsp_valid_o, dif.cmd_ready_o, dif.busy_o,
                                   dif.dtm_req_valid_o}), 64'(5'b00100));
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("rst_after_idle", 64'({dif.dtm_ack_o, dif.rsp_valid_o, dif.cmd_ready_o, dif.busy_o}),
            64'(4'b0010));
        wait_idle("rst");
        dm_skip_hold = 1'b0;

        // Host still works after the mid-transaction reset.
        dm_cfg(1, 1, 0, 1'b0);
        req_exp_q.push_back(dmi_pack(6'h10, 32'h0, DMI_OP_NOP));
        dm_rsp_q.push_back(dmi_pack(6'h10, 32'h0, DMI_RSP_OK));
        rsp_exp_q.push_back(dmi_pack(6'h10, 32'h0, DMI_RSP_OK));
        send(6'h10, 32'h0, DMI_OP_NOP, 1'b0, a0);
        wait_idle("post_rst");

        chk("queues_drained", 64'({req_exp_q.size() != 0, dm_rsp_q.size() != 0}), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
